// File: rtl/stop_watch_lap.sv
// Stopwatch with BCD live count, lap/split snapshot and sticky wrap flag.
// A prescaler divides clk by DVSR to produce a count tick; the live count
// keeps running while a lap snapshot is shown on bcd.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_LIVE   | bcd follows the live count, lap_active = 0
// S_FROZEN | bcd shows the snapshot taken at the lap edge, lap_active = 1
module stop_watch_lap #(
    parameter int DVSR  = 5000000,
    parameter int N_DIG = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               go,
    input  logic               clr,
    input  logic               up,
    input  logic               lap,
    output logic [4*N_DIG-1:0] bcd,
    output logic               lap_active,
    output logic               ovf,
    output logic               tick
);

    localparam int            PW        = $clog2(DVSR);
    localparam int            BW        = 4 * N_DIG;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DVSR - 1);

    typedef enum logic {
        S_LIVE   = 1'b0,
        S_FROZEN = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [BW-1:0] live_cnt;
    logic [BW-1:0] live_step;
    logic [BW-1:0] live_d;
    logic [BW-1:0] snap;
    logic          lap_q;
    logic          lap_edge;
    logic          wrap;
    logic          carry;
    logic [3:0]    dig;

    assign tick     = go & ~clr & (presc == PRESC_MAX);
    assign lap_edge = lap & ~lap_q;

    // One BCD step in the requested direction; carry out of the top digit is a wrap
    always_comb begin
        live_step = live_cnt;
        carry     = 1'b1;
        dig       = 4'd0;
        for (int k = 0; k < N_DIG; k++) begin
            dig = live_cnt[4*k +: 4];
            if (carry) begin
                if (up) begin
                    if (dig == 4'd9) begin
                        live_step[4*k +: 4] = 4'd0;
                    end else begin
                        live_step[4*k +: 4] = dig + 4'd1;
                        carry               = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        live_step[4*k +: 4] = 4'd9;
                    end else begin
                        live_step[4*k +: 4] = dig - 4'd1;
                        carry               = 1'b0;
                    end
                end
            end
        end
        wrap = carry;
    end

    // Live count value after the coming edge, used to keep bcd registered
    always_comb begin
        live_d = live_cnt;
        if (clr) begin
            live_d = '0;
        end else if (tick) begin
            live_d = live_step;
        end
    end

    // Prescaler, live count and sticky wrap flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            live_cnt <= '0;
            ovf      <= 1'b0;
        end else if (clr) begin
            presc    <= '0;
            live_cnt <= '0;
            ovf      <= 1'b0;
        end else if (go) begin
            presc    <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
            live_cnt <= live_d;
            if (tick && wrap) begin
                ovf <= 1'b1;
            end
        end
    end

    // Lap FSM with snapshot and registered display outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_LIVE;
            snap       <= '0;
            lap_q      <= 1'b0;
            bcd        <= '0;
            lap_active <= 1'b0;
        end else begin
            // lap_q tracks lap even during clr so a held lap cannot fire on release
            lap_q <= lap;
            if (clr) begin
                state      <= S_LIVE;
                snap       <= '0;
                bcd        <= '0;
                lap_active <= 1'b0;
            end else begin
                case (state)
                    S_LIVE: begin
                        if (lap_edge) begin
                            state      <= S_FROZEN;
                            snap       <= live_cnt;
                            bcd        <= live_cnt;
                            lap_active <= 1'b1;
                        end else begin
                            bcd <= live_d;
                        end
                    end
                    S_FROZEN: begin
                        if (lap_edge) begin
                            state      <= S_LIVE;
                            bcd        <= live_d;
                            lap_active <= 1'b0;
                        end else begin
                            bcd <= snap;
                        end
                    end
                    default: begin
                        state      <= S_LIVE;
                        bcd        <= live_d;
                        lap_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stop_watch_lap.sv
// Bench for stop_watch_lap: directed scenarios then random stimulus, checked
// against an integer-arithmetic model through an expected-output queue.
module tb_stop_watch_lap;

    localparam int DVSR  = 4;
    localparam int N_DIG = 2;
    localparam int BW    = 4 * N_DIG;
    localparam int MAXV  = 10 ** N_DIG - 1;

    logic          clk;
    logic          reset_n;
    logic          go;
    logic          clr;
    logic          up;
    logic          lap;
    logic [BW-1:0] bcd;
    logic          lap_active;
    logic          ovf;
    logic          tick;

    typedef struct packed {
        logic [BW-1:0] bcd;
        logic          la;
        logic          ovf;
        logic          tick;
    } obs_t;

    obs_t exp_q[$];
    int   vectors;
    int   miscompares;

    // Reference model state (plain integers)
    int m_presc;
    int m_live;
    int m_snap;
    bit m_frozen;
    bit m_ovf;
    bit m_lapq;

    stop_watch_lap #(.DVSR(DVSR), .N_DIG(N_DIG)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .clr        (clr),
        .up         (up),
        .lap        (lap),
        .bcd        (bcd),
        .lap_active (lap_active),
        .ovf        (ovf),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < N_DIG; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_presc  = 0;
        m_live   = 0;
        m_snap   = 0;
        m_frozen = 0;
        m_ovf    = 0;
        m_lapq   = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1: apply inputs for one cycle, queue the expected
    // outputs for this cycle, advance the model across the coming edge.
    task automatic drive(input bit g, input bit c, input bit u, input bit l, input bit pulse);
        obs_t e;
        bit   edge_l;
        reset_n = 1'b1;
        go  = g;
        clr = c;
        up  = u;
        lap = l;
        if (pulse) begin
            #1 reset_n = 1'b0;
            model_reset();
            #1;
            chk("async_rst_bcd",  32'(bcd),        32'd0);
            chk("async_rst_la",   32'(lap_active), 32'd0);
            chk("async_rst_ovf",  32'(ovf),        32'd0);
            chk("async_rst_tick", 32'(tick),       32'd0);
            #1 reset_n = 1'b1;
        end
        e.bcd  = m_frozen ? to_bcd(m_snap) : to_bcd(m_live);
        e.la   = m_frozen;
        e.ovf  = m_ovf;
        e.tick = g && !c && (m_presc == DVSR - 1);
        exp_q.push_back(e);

        edge_l = l && !m_lapq;
        m_lapq = l;
        if (c) begin
            m_presc  = 0;
            m_live   = 0;
            m_snap   = 0;
            m_ovf    = 0;
            m_frozen = 0;
        end else begin
            if (edge_l) begin
                if (!m_frozen) begin
                    m_snap   = m_live;
                    m_frozen = 1;
                end else begin
                    m_frozen = 0;
                end
            end
            if (g) begin
                if (m_presc == DVSR - 1) begin
                    m_presc = 0;
                    if (u) begin
                        if (m_live == MAXV) begin
                            m_live = 0;
                            m_ovf  = 1;
                        end else begin
                            m_live = m_live + 1;
                        end
                    end else begin
                        if (m_live == 0) begin
                            m_live = MAXV;
                            m_ovf  = 1;
                        end else begin
                            m_live = m_live - 1;
                        end
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents outputs, compare with the queue head
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bcd, lap_active, ovf, tick};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle_check @%0t: got bcd=%h la=%b ovf=%b tick=%b, expected bcd=%h la=%b ovf=%b tick=%b",
                             $time, a.bcd, a.la, a.ovf, a.tick, e.bcd, e.la, e.ovf, e.tick);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        reset_n = 1'b0;
        go      = 1'b1;
        clr     = 1'b0;
        up      = 1'b1;
        lap     = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_bcd",  32'(bcd),        32'd0);
        chk("reset_la",   32'(lap_active), 32'd0);
        chk("reset_ovf",  32'(ovf),        32'd0);
        chk("reset_tick", 32'(tick),       32'd0);

        // Count up from reset: 40 cycles -> 10 ticks
        repeat (40) drive(1, 0, 1, 0, 0);
        chk("up40_bcd", 32'(bcd), 32'h10);

        // Up to 99, then wrap
        repeat (356) drive(1, 0, 1, 0, 0);
        chk("preload99", 32'(bcd), 32'h99);
        repeat (4) drive(1, 0, 1, 0, 0);
        chk("upwrap_bcd", 32'(bcd), 32'h00);
        chk("upwrap_ovf", 32'(ovf), 32'd1);
        repeat (5) drive(0, 0, 1, 0, 0);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        drive(0, 1, 1, 0, 0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_bcd", 32'(bcd), 32'h00);

        // Down wrap
        repeat (4) drive(1, 0, 0, 0, 0);
        chk("dnwrap_bcd", 32'(bcd), 32'h99);
        chk("dnwrap_ovf", 32'(ovf), 32'd1);
        repeat (8) drive(1, 0, 0, 0, 0);
        chk("dn_97", 32'(bcd), 32'h97);

        // Lap on a tick cycle at 0x23, release at 0x27
        drive(1, 1, 1, 0, 0);
        repeat (92) drive(1, 0, 1, 0, 0);
        repeat (3) drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 1, 0);
        chk("lap_snap_bcd", 32'(bcd), 32'h23);
        chk("lap_snap_la",  32'(lap_active), 32'd1);
        repeat (12) drive(1, 0, 1, 0, 0);
        chk("lap_hold_bcd", 32'(bcd), 32'h23);
        drive(1, 0, 1, 1, 0);
        chk("lap_rel_bcd", 32'(bcd), 32'h27);
        chk("lap_rel_la",  32'(lap_active), 32'd0);

        // Held lap, clr with lap high, release clr with lap still high
        drive(1, 0, 1, 0, 0);
        repeat (10) drive(1, 0, 1, 1, 0);
        chk("lap_held_la", 32'(lap_active), 32'd1);
        drive(1, 1, 1, 1, 0);
        chk("clr_lap_la",  32'(lap_active), 32'd0);
        chk("clr_lap_bcd", 32'(bcd), 32'h00);
        repeat (5) drive(1, 0, 1, 1, 0);
        chk("clr_rel_la", 32'(lap_active), 32'd0);

        // Frozen with ovf set, then async reset pulse between edges
        drive(1, 1, 1, 0, 0);
        repeat (4) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        chk("pre_rst_la",  32'(lap_active), 32'd1);
        chk("pre_rst_ovf", 32'(ovf), 32'd1);
        drive(1, 0, 0, 0, 1);

        // Randomized phase
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 99) < 85,
                  $urandom_range(0, 49) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 199) == 0);
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stop_watch_lap.md
STOP_WATCH_LAP -- requirements
Module: stop_watch_lap

Interface
REQ-001 Parameter DVSR, default 5000000, prescaler modulus (clk cycles per count tick); legal range >= 2.
REQ-002 Parameter N_DIG, default 4, number of BCD digits; legal range 1..8.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port go  input  1  level; 1 = run, 0 = pause; counter and prescaler hold.
REQ-006 Port clr  input  1  level, synchronous clear of count, prescaler, lap state and ovf.
REQ-007 Port up  input  1  count direction, sampled each tick; 1 = increment, 0 = decrement.
REQ-008 Port lap  input  1  lap/split request, acted on at 0->1 transition only.
REQ-009 Port bcd  output  4*N_DIG  displayed value; digit k occupies bits [4k+3:4k]; digit 0 is least significant.
REQ-010 Port lap_active  output  1  1 = bcd shows frozen lap snapshot.
REQ-011 Port ovf  output  1  sticky wrap flag.
REQ-012 Port tick  output  1  one-cycle pulse in each cycle the live count steps.

Function
REQ-013 Prescaler: counts 0..DVSR-1 while go=1; wraps to 0 after DVSR-1; holds while go=0; width = ceil(log2(DVSR)).
REQ-014 tick = 1 iff go=1, clr=0 and prescaler = DVSR-1; live count steps in that same clock edge.
REQ-015 Live count: N_DIG cascaded BCD digits, each always 0..9; digit k carries/borrows only when all lower digits are at 9 (up) or 0 (down).
REQ-016 Up wrap: live = all 9s with tick and up=1 -> all 0s, ovf set to 1.
REQ-017 Down wrap: live = all 0s with tick and up=0 -> all 9s, ovf set to 1.
REQ-018 ovf is sticky; cleared only by clr or reset.
REQ-019 lap edge detect: registered copy of lap; lap_edge = lap & ~lap_q.
REQ-020 Two-state FSM: LIVE (lap_active=0, bcd = live count) and FROZEN (lap_active=1, bcd = snapshot register).
REQ-021 LIVE -> FROZEN on lap_edge; snapshot loads the live count value present before that edge, i.e. the pre-increment value if tick occurs in the same cycle.
REQ-022 FROZEN -> LIVE on lap_edge; snapshot register holds its value (don't-care to outputs).
REQ-023 Live count, prescaler and ovf continue to run in FROZEN exactly as in LIVE.
REQ-024 clr priority: clr=1 forces prescaler=0, live count=0, snapshot=0, ovf=0, FSM=LIVE, tick=0; a simultaneous lap_edge is ignored and tick is suppressed.
REQ-025 lap_q updates every cycle, including while clr=1, so a lap held high across clr release does not produce an edge.
REQ-026 go has no effect on lap handling; lap is accepted while paused.
REQ-027 bcd, lap_active and ovf are driven directly from registers (no combinational path from inputs); tick is combinational from prescaler, go and clr.

Reset
REQ-028 reset_n=0 asynchronously forces prescaler=0, live count=0, snapshot=0, lap_q=0, ovf=0, FSM=LIVE.
REQ-029 During reset: bcd=0, lap_active=0, ovf=0, tick=0; first count step occurs DVSR cycles after reset_n release with go=1.
REQ-030 Reset asserted mid-count or in FROZEN takes effect immediately, without waiting for a clk edge.

Verification (DVSR=4, N_DIG=2)
REQ-031 Reset release, go=1, up=1 for 40 cycles -> tick every 4th cycle, bcd=0x10 after cycle 40.
REQ-032 Preload 0x99 by counting, up=1, one more tick -> bcd=0x00, ovf=1; ovf stays 1 until clr=1 for one cycle, then ovf=0 and bcd=0x00.
REQ-033 From 0x00, up=0, one tick -> bcd=0x99, ovf=1; further ticks -> 0x98, 0x97.
REQ-034 At live=0x23, lap 0->1 in the same cycle as tick -> lap_active=1, bcd=0x23 held while live advances; second lap edge at live=0x27 -> bcd=0x27, lap_active=0.
REQ-035 Hold lap=1 for 10 cycles -> exactly one FROZEN transition; clr with lap=1 -> LIVE, bcd=0x00; release clr with lap still 1 -> no transition.
REQ-036 Pulse reset_n low between clk edges while in FROZEN with ovf=1 -> all outputs 0 before the next clk edge.
